// File: rtl/data_sram_responder_pkg.sv
// Shared constants and types for the data-side SRAM/MMIO responder.
package data_sram_responder_pkg;

    localparam int          RAM_AWIDTH_DEF = 10;
    localparam logic [31:0] MMIO_BASE_DEF  = 32'hBFAF_F000;

    // Byte offsets of the MMIO registers inside the 4 KiB window
    localparam logic [11:0] OFF_TIMER      = 12'h000;
    localparam logic [11:0] OFF_TIMER_CMP  = 12'h004;
    localparam logic [11:0] OFF_INT_STATUS = 12'h008;
    localparam logic [11:0] OFF_INT_MASK   = 12'h00C;
    localparam logic [11:0] OFF_SW_INT     = 12'h010;

    // Interrupt bit indices
    localparam int INT_TIMER_BIT = 0;
    localparam int INT_SW_LO_BIT = 1;
    localparam int INT_SW_HI_BIT = 7;

    typedef enum logic [2:0] {
        REG_TIMER,
        REG_TIMER_CMP,
        REG_INT_STATUS,
        REG_INT_MASK,
        REG_SW_INT,
        REG_NONE
    } mmio_reg_e;

    // Word offset (addr[11:2]) to register select
    function automatic mmio_reg_e decode_reg(input logic [9:0] woff);
        logic [11:0] boff;
        boff = {woff, 2'b00};
        if (boff == OFF_TIMER)           return REG_TIMER;
        else if (boff == OFF_TIMER_CMP)  return REG_TIMER_CMP;
        else if (boff == OFF_INT_STATUS) return REG_INT_STATUS;
        else if (boff == OFF_INT_MASK)   return REG_INT_MASK;
        else if (boff == OFF_SW_INT)     return REG_SW_INT;
        else                             return REG_NONE;
    endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// Core data-side SRAM bus: request from the core, read data back.
interface data_sram_responder_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
        input  data_sram_rdata
    );

    modport slave (
        input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
        output data_sram_rdata
    );
endinterface

// File: rtl/data_sram_responder_sram_byte_we_1p.sv
// Single-port 32-bit RAM with byte enables and a registered 1-cycle read.
// Only the read register is reset; the array keeps its contents.
module sram_byte_we_1p #(
    parameter int AWIDTH = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic [3:0]        we_i,
    input  logic [AWIDTH-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [2**AWIDTH];
    logic [31:0] rdata_q;

    // Byte-lane writes into the array
    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int i = 0; i < 4; i++) begin
                if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    // Read register: loads on reads only, holds otherwise
    always_ff @(posedge clk) begin
        if (rst)                        rdata_q <= '0;
        else if (en_i && we_i == 4'h0)  rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_sram_responder.sv
// Data-side responder: decodes core accesses into backing RAM or a small
// timer/interrupt MMIO block, and drives the registered interrupt lines.
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int          RAM_AWIDTH = RAM_AWIDTH_DEF,
    parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    data_sram_responder_if.slave   bus,
    output logic [7:0]             hardware_interrupt_data
);

    logic        is_mmio, acc, rd, mmio_wr, ram_en;
    mmio_reg_e   reg_sel;
    logic [31:0] ram_rdata;
    logic [7:0]  status;
    logic        unused_addr_lsb;

    logic [31:0] timer_q, timer_d;
    logic [31:0] cmp_q, cmp_d;
    logic        st0_q, st0_d;
    logic [7:0]  mask_q, mask_d;
    logic [7:1]  sw_q, sw_d;
    logic [7:0]  irq_q, irq_d;
    logic        region_q, region_d;
    logic [31:0] mmio_rdata_q, mmio_rdata_d;

    // Accesses presented during reset are dropped entirely
    assign is_mmio = (bus.data_sram_addr[31:12] == MMIO_BASE[31:12]);
    assign acc     = bus.data_sram_en & ~rst;
    assign rd      = acc & (bus.data_sram_we == 4'h0);
    assign mmio_wr = acc & is_mmio & (bus.data_sram_we == 4'hF);
    assign ram_en  = acc & ~is_mmio;
    assign reg_sel = decode_reg(bus.data_sram_addr[11:2]);
    assign status  = {sw_q, st0_q};
    assign unused_addr_lsb = ^bus.data_sram_addr[1:0];

    sram_byte_we_1p #(.AWIDTH(RAM_AWIDTH)) u_ram (
        .clk     (clk),
        .rst     (rst),
        .en_i    (ram_en),
        .we_i    (bus.data_sram_we),
        .addr_i  (bus.data_sram_addr[RAM_AWIDTH+1:2]),
        .wdata_i (bus.data_sram_wdata),
        .rdata_o (ram_rdata)
    );

    // MMIO register next-state, interrupt status and read capture
    always_comb begin
        timer_d      = timer_q + 32'd1;
        cmp_d        = cmp_q;
        st0_d        = st0_q;
        mask_d       = mask_q;
        sw_d         = sw_q;
        region_d     = region_q;
        mmio_rdata_d = mmio_rdata_q;

        if (mmio_wr) begin
            case (reg_sel)
                REG_TIMER:      timer_d = bus.data_sram_wdata;
                REG_TIMER_CMP:  cmp_d   = bus.data_sram_wdata;
                REG_INT_STATUS: if (bus.data_sram_wdata[INT_TIMER_BIT]) st0_d = 1'b0;
                REG_INT_MASK:   mask_d  = bus.data_sram_wdata[7:0];
                REG_SW_INT:     sw_d    = bus.data_sram_wdata[INT_SW_HI_BIT:INT_SW_LO_BIT];
                default: ;
            endcase
        end

        // Placed after the W1C so a coincident match keeps the bit set
        if (timer_q == cmp_q && cmp_q != 32'd0) st0_d = 1'b1;

        irq_d = status & mask_q;

        if (rd) begin
            region_d = is_mmio;
            if (is_mmio) begin
                case (reg_sel)
                    REG_TIMER:      mmio_rdata_d = timer_q;
                    REG_TIMER_CMP:  mmio_rdata_d = cmp_q;
                    REG_INT_STATUS: mmio_rdata_d = {24'h0, status};
                    REG_INT_MASK:   mmio_rdata_d = {24'h0, mask_q};
                    REG_SW_INT:     mmio_rdata_d = {24'h0, sw_q, 1'b0};
                    default:        mmio_rdata_d = 32'h0;
                endcase
            end
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q      <= '0;
            cmp_q        <= '0;
            st0_q        <= 1'b0;
            mask_q       <= '0;
            sw_q         <= '0;
            irq_q        <= '0;
            region_q     <= 1'b0;
            mmio_rdata_q <= '0;
        end else begin
            timer_q      <= timer_d;
            cmp_q        <= cmp_d;
            st0_q        <= st0_d;
            mask_q       <= mask_d;
            sw_q         <= sw_d;
            irq_q        <= irq_d;
            region_q     <= region_d;
            mmio_rdata_q <= mmio_rdata_d;
        end
    end

    assign bus.data_sram_rdata     = region_q ? mmio_rdata_q : ram_rdata;
    assign hardware_interrupt_data = irq_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Scoreboard bench: stimulus pushes cycle-stamped expectations, a negedge
// monitor compares rdata / interrupt lines when each stamp comes due.
module tb_data_sram_responder;

    localparam logic [31:0] MB  = 32'hBFAF_F000;
    localparam logic [31:0] A_TIMER  = MB + 32'h000;
    localparam logic [31:0] A_CMP    = MB + 32'h004;
    localparam logic [31:0] A_STATUS = MB + 32'h008;
    localparam logic [31:0] A_MASK   = MB + 32'h00C;
    localparam logic [31:0] A_SW     = MB + 32'h010;
    localparam logic [31:0] A_UNMAP  = 32'hBFAF_F0F0;

    typedef struct {
        int          cyc;
        bit          irq;
        logic [31:0] val;
        string       name;
    } chk_t;

    logic       clk;
    logic       rst;
    logic [7:0] hw_irq;
    int         cyc;
    int         checks;
    int         errors;
    chk_t       q[$];

    data_sram_responder_if bus ();

    data_sram_responder dut (
        .clk                     (clk),
        .rst                     (rst),
        .bus                     (bus),
        .hardware_interrupt_data (hw_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation stamped for the current cycle
    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == cyc) begin
                logic [31:0] got;
                got = q[i].irq ? {24'h0, hw_irq} : bus.data_sram_rdata;
                checks++;
                if (got !== q[i].val) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h (cycle %0d)",
                             q[i].name, got, q[i].val, cyc);
                end
                q.delete(i);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic push(input int c, input bit irq, input logic [31:0] v, input string n);
        chk_t e;
        e.cyc = c; e.irq = irq; e.val = v; e.name = n;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [3:0] we,
                         input logic [31:0] a, input logic [31:0] d);
        bus.data_sram_en    = en;
        bus.data_sram_we    = we;
        bus.data_sram_addr  = a;
        bus.data_sram_wdata = d;
        step();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        drive(1'b1, we, a, d);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string n);
        push(cyc + 1, 1'b0, exp, n);
        drive(1'b1, 4'h0, a, 32'h0);
    endtask

    task automatic idle();
        drive(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic idle_hold(input logic [31:0] exp, input string n);
        push(cyc + 1, 1'b0, exp, n);
        idle();
    endtask

    initial begin
        int w, t, k, c;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.data_sram_en    = 1'b0;
        bus.data_sram_we    = 4'h0;
        bus.data_sram_addr  = 32'h0;
        bus.data_sram_wdata = 32'h0;
        step();
        push(cyc + 1, 1'b0, 32'h0, "rst_rdata");
        push(cyc + 1, 1'b1, 32'h0, "rst_irq");
        step();
        rst = 1'b0;

        // RAM lane merge, hold, back-to-back, alias
        wr(32'h10, 32'h1234_5678, 4'hF);
        wr(32'h10, 32'hAAAA_AAAA, 4'b0010);
        rd(32'h10, 32'h1234_AA78, "lane_merge");
        idle_hold(32'h1234_AA78, "hold_idle1");
        idle_hold(32'h1234_AA78, "hold_idle2");
        idle_hold(32'h1234_AA78, "hold_idle3");
        push(cyc + 1, 1'b0, 32'h1234_AA78, "hold_write");
        wr(32'h20, 32'hDEAD_BEEF, 4'hF);
        rd(32'h20, 32'hDEAD_BEEF, "b2b_wr_rd");
        wr(32'h20, 32'h1122_3344, 4'b1100);
        rd(32'h20, 32'h1122_BEEF, "lane_hi");
        rd(32'h1010, 32'h1234_AA78, "alias");

        // Timer match: TIMER=0 at w, so TIMER==20 during cycle w+21
        w = cyc;
        wr(A_TIMER, 32'd0, 4'hF);
        wr(A_CMP, 32'd20, 4'hF);
        wr(A_MASK, 32'h01, 4'hF);
        t = w + 21;
        push(t + 1, 1'b1, 32'h00, "irq_pre");
        push(t + 2, 1'b1, 32'h01, "irq_set");
        rd(A_STATUS, 32'h0, "st_before");
        while (cyc < t + 1) idle();
        rd(A_STATUS, 32'h1, "st_set");
        idle();
        idle();

        // W1C without a match: lines drop two cycles after the write
        k = cyc;
        push(k + 1, 1'b1, 32'h01, "irq_before_clr");
        push(k + 2, 1'b1, 32'h00, "irq_clr");
        wr(A_STATUS, 32'h1, 4'hF);
        rd(A_STATUS, 32'h0, "st_clr");

        // W1C coincident with a match (TIMER=18 at w -> 20 at w+3)
        w = cyc;
        push(w + 4, 1'b1, 32'h00, "irq_set_wins_lag");
        push(w + 5, 1'b1, 32'h01, "irq_set_wins");
        wr(A_TIMER, 32'd18, 4'hF);
        idle();
        idle();
        wr(A_STATUS, 32'h1, 4'hF);
        rd(A_STATUS, 32'h1, "st_set_wins");

        // Wrap: FFFF_FFFE loaded at w, read at w+4 sees FFFF_FFFE+3 = 1
        wr(A_TIMER, 32'hFFFF_FFFE, 4'hF);
        idle();
        idle();
        idle();
        rd(A_TIMER, 32'h1, "timer_wrap");

        // Software interrupts, masking, partial and unmapped accesses
        c = cyc;
        push(c + 4, 1'b1, 32'h01, "irq_sw_old_mask");
        push(c + 5, 1'b1, 32'hF0, "irq_masked");
        wr(A_SW, 32'hFF, 4'hF);
        rd(A_SW, 32'hFE, "sw_read");
        rd(A_STATUS, 32'hFF, "st_sw");
        wr(A_MASK, 32'hF0, 4'hF);
        wr(A_MASK, 32'h0, 4'b0001);
        rd(A_MASK, 32'hF0, "mask_partial");
        wr(A_UNMAP, 32'hFFFF_FFFF, 4'hF);
        rd(A_UNMAP, 32'h0, "unmapped");

        // Reset mid-run with accesses presented during reset
        rd(32'h10, 32'h1234_AA78, "pre_rst");
        rst = 1'b1;
        push(cyc + 1, 1'b0, 32'h0, "rst_drop_rdata");
        push(cyc + 1, 1'b1, 32'h0, "rst_irq2");
        drive(1'b1, 4'h0, 32'h10, 32'h0);
        drive(1'b1, 4'hF, 32'h10, 32'h0);
        rst = 1'b0;
        push(cyc + 1, 1'b1, 32'h0, "irq_after_rst");
        rd(A_TIMER, 32'h0, "timer_after_rst");
        rd(32'h10, 32'h1234_AA78, "ram_kept");
        rd(A_CMP, 32'h0, "cmp_after_rst");
        rd(A_MASK, 32'h0, "mask_after_rst");
        rd(A_STATUS, 32'h0, "st_after_rst");
        idle();
        idle();
        idle();

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_sram_responder.md
DATA_SRAM_RESPONDER -- requirements
Module: data_sram_responder

Interface
REQ-001 SHALL have parameter RAM_AWIDTH, default 10, meaning word-address bits of backing RAM (1024 words, 4 KiB).
REQ-002 SHALL have parameter MMIO_BASE, default 32'hBFAF_F000, meaning base of the 4 KiB peripheral window.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 data_sram_en  input  1  access request this cycle.
REQ-006 data_sram_we  input  4  byte write enables; 0 = read.
REQ-007 data_sram_addr  input  32  byte address; bits [1:0] ignored.
REQ-008 data_sram_wdata  input  32  write data.
REQ-009 data_sram_rdata  output  32  read data, one cycle after request.
REQ-010 hardware_interrupt_data  output  8  interrupt lines to core, registered.

Function
REQ-011 Address decode: addr[31:12]==MMIO_BASE[31:12] selects MMIO; all other addresses select RAM at word index addr[RAM_AWIDTH+1:2] (aliasing above).
REQ-012 Read latency exactly 1: en=1, we=0 in cycle N drives rdata in cycle N+1.
REQ-013 rdata SHALL hold its last value in any cycle following en=0 or en=1 with we!=0.
REQ-014 RAM write: each byte lane i written iff en & we[i]; other lanes untouched.
REQ-015 Read-first: a read same-cycle as a write cannot occur (single port); back-to-back write N, read N+1 same word returns the new data.
REQ-016 MMIO registers (offset): 0x000 TIMER R/W, 0x004 TIMER_CMP R/W, 0x008 INT_STATUS R/W1C, 0x00C INT_MASK R/W (bits[7:0]), 0x010 SW_INT R/W (bits[7:1]).
REQ-017 MMIO writes take effect only when we==4'hF; partial-lane MMIO writes are ignored.
REQ-018 Reads of unmapped MMIO offsets return 32'h0; writes to them are ignored.
REQ-019 TIMER increments by 1 every cycle, wrapping 32'hFFFF_FFFF -> 0; a CPU write loads the written value that cycle (no increment that cycle).
REQ-020 When TIMER==TIMER_CMP and TIMER_CMP!=0, INT_STATUS[0] sets on the next edge.
REQ-021 INT_STATUS[7:1] = SW_INT[7:1] continuously; W1C affects bit 0 only.
REQ-022 Simultaneous timer-match set and W1C clear of bit 0: set wins.
REQ-023 hardware_interrupt_data registered = INT_STATUS[7:0] & INT_MASK[7:0]; one-cycle lag from status change.
REQ-024 INT_STATUS read returns {24'h0, status}; INT_MASK/SW_INT reads zero-extend.

Reset
REQ-025 On rst=1 at an edge: rdata=0, hardware_interrupt_data=0, TIMER=0, TIMER_CMP=0, INT_STATUS=0, INT_MASK=0, SW_INT=0.
REQ-026 RAM contents SHALL NOT be reset; an access presented with rst=1 is dropped (no write, rdata=0).
REQ-027 Reset mid-sequence: first access after rst deasserts behaves per REQ-012 with no residue.

Structure
REQ-028 Shared package holds MMIO_BASE default, register offsets, INT bit indices, RAM_AWIDTH default.
REQ-029 One sub-module: sram_byte_we_1p (single-port, 32-bit, byte-enable, 1-cycle read); MMIO and decode live in top.
REQ-030 Read-data mux selects between RAM output and a registered MMIO read value using a registered region flag.

Verification
REQ-031 Write 0x1234_5678 we=F to 0x0000_0010, then we=4'b0010 data 0xAAAA_AAAA, read -> 0x1234_AA78 one cycle after read request.
REQ-032 Read 0x0000_0010 then idle 3 cycles -> rdata stays 0x1234_AA78.
REQ-033 Write TIMER_CMP=20, INT_MASK=0x01 after reset -> INT_STATUS[0] sets when TIMER reaches 20; hardware_interrupt_data=0x01 one cycle later.
REQ-034 W1C 0x1 to INT_STATUS in same cycle as a match -> bit stays 1; W1C without match -> output 0x00 two cycles later.
REQ-035 Write TIMER=0xFFFF_FFFE, read TIMER 3 cycles later -> 0x0000_0001 (wrap).
REQ-036 Partial write we=4'b0001 to INT_MASK, read unmapped 0xBFAF_F0F0, assert rst mid-run -> mask unchanged, read 0, all outputs 0 after reset.
